// File: rtl/wrp_tap_ctrl.sv
// TAP controller and instruction decoder for a six-cell boundary scan wrapper chain.
// It drives the chain strobes, the segment enables and the cell-mode selects, and it muxes TDO.
module wrp_tap_ctrl #(
  parameter int              IR_W       = 4,
  parameter logic [IR_W-1:0] OP_WRP_IN  = IR_W'(4'h1),
  parameter logic [IR_W-1:0] OP_WRP_OUT = IR_W'(4'h2),
  parameter logic [IR_W-1:0] OP_WRP_ALL = IR_W'(4'h3)
) (
  input  logic            TDR_TCK,
  input  logic            TDR_TRESETN,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic            TDO_EN,
  output logic            CTI,
  input  logic            CTO,
  output logic            TDR_CAPTURE,
  output logic            TDR_SHIFT,
  output logic            TDR_UPDATE,
  output logic            INSCANWRAP_TDR_EN,
  output logic            OUTSCANWRAP_TDR_EN,
  output logic            inscanwrap_sel,
  output logic            outscanwrap_sel,
  output logic [IR_W-1:0] ir_out
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SHF_DR = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SHF_IR = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_t;

  tap_state_t      state_r;
  tap_state_t      next_state_s;
  logic [IR_W-1:0] ir_shift_r;
  logic [IR_W-1:0] ir_active_r;
  logic [IR_W-1:0] ir_active_nxt_s;
  logic            bypass_r;
  logic            wrp_in_r;
  logic            wrp_out_r;
  logic            wrp_sel_s;
  logic            capture_s;
  logic            shift_s;
  logic            update_s;
  logic            tdo_s;
  logic            tdo_en_s;

  function automatic logic dec_wrp_in(input logic [IR_W-1:0] op);
    return (op == OP_WRP_IN) || (op == OP_WRP_ALL);
  endfunction

  function automatic logic dec_wrp_out(input logic [IR_W-1:0] op);
    return (op == OP_WRP_OUT) || (op == OP_WRP_ALL);
  endfunction

  // TAP state register
  always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN) begin
      state_r <= TLR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Standard 1149.1 TMS transition table
  always_comb begin
    next_state_s = TLR;
    case (state_r)
      TLR:     next_state_s = TMS ? TLR    : RTI;
      RTI:     next_state_s = TMS ? SEL_DR : RTI;
      SEL_DR:  next_state_s = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  next_state_s = TMS ? EX1_DR : SHF_DR;
      SHF_DR:  next_state_s = TMS ? EX1_DR : SHF_DR;
      EX1_DR:  next_state_s = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  next_state_s = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  next_state_s = TMS ? UPD_DR : SHF_DR;
      UPD_DR:  next_state_s = TMS ? SEL_DR : RTI;
      SEL_IR:  next_state_s = TMS ? TLR    : CAP_IR;
      CAP_IR:  next_state_s = TMS ? EX1_IR : SHF_IR;
      SHF_IR:  next_state_s = TMS ? EX1_IR : SHF_IR;
      EX1_IR:  next_state_s = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  next_state_s = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  next_state_s = TMS ? UPD_IR : SHF_IR;
      UPD_IR:  next_state_s = TMS ? SEL_DR : RTI;
      default: next_state_s = TLR;
    endcase
  end

  // Next active instruction; decode is taken from this so it lands together with ir_active
  always_comb begin
    ir_active_nxt_s = ir_active_r;
    if (next_state_s == TLR) begin
      ir_active_nxt_s = '1;
    end else if (state_r == UPD_IR) begin
      ir_active_nxt_s = ir_shift_r;
    end else begin
      ir_active_nxt_s = ir_active_r;
    end
  end

  // Active instruction and registered decode
  always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN) begin
      ir_active_r <= '1;
      wrp_in_r    <= 1'b0;
      wrp_out_r   <= 1'b0;
    end else begin
      ir_active_r <= ir_active_nxt_s;
      wrp_in_r    <= dec_wrp_in(ir_active_nxt_s);
      wrp_out_r   <= dec_wrp_out(ir_active_nxt_s);
    end
  end

  assign wrp_sel_s = wrp_in_r | wrp_out_r;

  // IR shift stage and bypass bit
  always_ff @(posedge TDR_TCK or negedge TDR_TRESETN) begin
    if (!TDR_TRESETN) begin
      ir_shift_r <= '1;
      bypass_r   <= 1'b0;
    end else begin
      case (state_r)
        CAP_IR:  ir_shift_r <= IR_W'(2'b01);
        SHF_IR:  ir_shift_r <= {TDI, ir_shift_r[IR_W-1:1]};
        CAP_DR:  if (!wrp_sel_s) bypass_r <= 1'b0;
        SHF_DR:  if (!wrp_sel_s) bypass_r <= TDI;
        default: bypass_r <= bypass_r;
      endcase
    end
  end

  // Moore strobes and TDO mux from the current state
  always_comb begin
    capture_s = 1'b0;
    shift_s   = 1'b0;
    update_s  = 1'b0;
    tdo_s     = 1'b0;
    tdo_en_s  = 1'b0;
    case (state_r)
      CAP_DR: capture_s = wrp_sel_s;
      UPD_DR: update_s  = wrp_sel_s;
      SHF_DR: begin
        shift_s  = wrp_sel_s;
        tdo_en_s = 1'b1;
        tdo_s    = wrp_sel_s ? CTO : bypass_r;
      end
      SHF_IR: begin
        tdo_en_s = 1'b1;
        tdo_s    = ir_shift_r[0];
      end
      default: tdo_s = 1'b0;
    endcase
  end

  assign CTI                = TDI;
  assign TDO                = tdo_s;
  assign TDO_EN             = tdo_en_s;
  assign TDR_CAPTURE        = capture_s;
  assign TDR_SHIFT          = shift_s;
  assign TDR_UPDATE         = update_s;
  assign INSCANWRAP_TDR_EN  = wrp_in_r;
  assign inscanwrap_sel     = wrp_in_r;
  assign OUTSCANWRAP_TDR_EN = wrp_out_r;
  assign outscanwrap_sel    = wrp_out_r;
  assign ir_out             = ir_active_r;

endmodule

// File: tb/tb_wrp_tap_ctrl.sv
// Directed, table-driven bench for wrp_tap_ctrl.
// Each vector holds the TMS/TDI/CTO inputs and the outputs expected in the current state.
module tb_wrp_tap_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tms;
  logic       tdi;
  logic       cto;
  logic       tdo;
  logic       tdo_en;
  logic       cti;
  logic       cap;
  logic       shf;
  logic       upd;
  logic       in_en;
  logic       out_en;
  logic       in_sel;
  logic       out_sel;
  logic [3:0] ir_out;
  logic [8:0] obs;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Expected-output bit groups: {tdo, tdo_en, cap, shf, upd, in_en, out_en, in_sel, out_sel}
  localparam logic [8:0] P_TDO = 9'h100;
  localparam logic [8:0] P_EN  = 9'h080;
  localparam logic [8:0] P_CAP = 9'h040;
  localparam logic [8:0] P_SHF = 9'h020;
  localparam logic [8:0] P_UPD = 9'h010;
  localparam logic [8:0] P_ALL = 9'h00F;
  localparam logic [8:0] P_IN  = 9'h00A;
  localparam logic [8:0] P_Z   = 9'h000;

  typedef struct {
    logic       tms;
    logic       tdi;
    logic       cto;
    logic [8:0] exp_o;
    logic [3:0] exp_ir;
  } vec_t;

  vec_t vecs[$];

  wrp_tap_ctrl dut (
    .TDR_TCK            (clk),
    .TDR_TRESETN        (rst_n),
    .TMS                (tms),
    .TDI                (tdi),
    .TDO                (tdo),
    .TDO_EN             (tdo_en),
    .CTI                (cti),
    .CTO                (cto),
    .TDR_CAPTURE        (cap),
    .TDR_SHIFT          (shf),
    .TDR_UPDATE         (upd),
    .INSCANWRAP_TDR_EN  (in_en),
    .OUTSCANWRAP_TDR_EN (out_en),
    .inscanwrap_sel     (in_sel),
    .outscanwrap_sel    (out_sel),
    .ir_out             (ir_out)
  );

  assign obs = {tdo, tdo_en, cap, shf, upd, in_en, out_en, in_sel, out_sel};

  always #5 clk = ~clk;

  task automatic add(input logic t, input logic d, input logic c,
                     input logic [8:0] e, input logic [3:0] ir);
    vec_t v;
    v.tms = t; v.tdi = d; v.cto = c; v.exp_o = e; v.exp_ir = ir;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [8:0] e, input logic [3:0] ir);
    chk_cnt++;
    if (obs === e && ir_out === ir) pass_cnt++;
    else $display("FAIL %s: got outs=%b ir=%h, want outs=%b ir=%h", nm, obs, ir_out, e, ir);
  endtask

  task automatic step(input logic t, input logic d);
    @(negedge clk);
    tms = t;
    tdi = d;
    @(posedge clk);
  endtask

  initial begin
    // Power-on/reset, then five TMS=1 and a short loop through SEL_IR back to TLR
    repeat (5) add(1'b1, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b0, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b1, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b1, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b1, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b0, 1'b0, 1'b0, P_Z, 4'hF);
    // Load WRP_ALL: TDI 1,1,0,0 LSB first; TDO shows captured 0001
    add(1'b1, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b1, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b0, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b0, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b0, 1'b1, 1'b0, P_EN | P_TDO, 4'hF);
    add(1'b0, 1'b1, 1'b0, P_EN, 4'hF);
    add(1'b0, 1'b0, 1'b0, P_EN, 4'hF);
    add(1'b1, 1'b0, 1'b0, P_EN, 4'hF);
    add(1'b1, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b0, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b0, 1'b0, 1'b0, P_ALL, 4'h3);
    // DR scan under WRP_ALL: capture, six shifts with TDO = CTO, update
    add(1'b1, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL | P_CAP, 4'h3);
    add(1'b0, 1'b1, 1'b0, P_ALL | P_SHF | P_EN, 4'h3);
    add(1'b0, 1'b0, 1'b1, P_ALL | P_SHF | P_EN | P_TDO, 4'h3);
    add(1'b0, 1'b1, 1'b1, P_ALL | P_SHF | P_EN | P_TDO, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL | P_SHF | P_EN, 4'h3);
    add(1'b0, 1'b1, 1'b1, P_ALL | P_SHF | P_EN | P_TDO, 4'h3);
    add(1'b1, 1'b0, 1'b1, P_ALL | P_SHF | P_EN | P_TDO, 4'h3);
    add(1'b1, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL | P_UPD, 4'h3);
    // DR scan through PAUSE_DR: no strobes, no TDO while paused
    add(1'b1, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL | P_CAP, 4'h3);
    add(1'b1, 1'b1, 1'b1, P_ALL | P_SHF | P_EN | P_TDO, 4'h3);
    add(1'b0, 1'b0, 1'b1, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b1, P_ALL, 4'h3);
    add(1'b1, 1'b0, 1'b1, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b1, P_ALL, 4'h3);
    add(1'b1, 1'b0, 1'b1, P_ALL | P_SHF | P_EN | P_TDO, 4'h3);
    add(1'b1, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL | P_UPD, 4'h3);
    // Load WRP_IN: TDI 1,0,0,0
    add(1'b1, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b1, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b1, 1'b0, P_ALL | P_EN | P_TDO, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL | P_EN, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL | P_EN, 4'h3);
    add(1'b1, 1'b0, 1'b0, P_ALL | P_EN, 4'h3);
    add(1'b1, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_ALL, 4'h3);
    add(1'b0, 1'b0, 1'b0, P_IN, 4'h1);
    // Enter SHF_DR under WRP_IN, then five TMS=1 back to TLR (reloads BYPASS)
    add(1'b1, 1'b0, 1'b0, P_IN, 4'h1);
    add(1'b0, 1'b0, 1'b0, P_IN, 4'h1);
    add(1'b0, 1'b0, 1'b0, P_IN | P_CAP, 4'h1);
    add(1'b0, 1'b1, 1'b1, P_IN | P_SHF | P_EN | P_TDO, 4'h1);
    add(1'b1, 1'b0, 1'b0, P_IN | P_SHF | P_EN, 4'h1);
    add(1'b1, 1'b0, 1'b0, P_IN, 4'h1);
    add(1'b1, 1'b0, 1'b0, P_IN | P_UPD, 4'h1);
    add(1'b1, 1'b0, 1'b0, P_IN, 4'h1);
    add(1'b1, 1'b0, 1'b0, P_IN, 4'h1);
    add(1'b0, 1'b0, 1'b0, P_Z, 4'hF);
    // BYPASS DR shift 1,0,1,1 -> TDO 0,1,0,1, CTO ignored, no strobes
    add(1'b1, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b0, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b0, 1'b0, 1'b1, P_Z, 4'hF);
    add(1'b0, 1'b1, 1'b1, P_EN, 4'hF);
    add(1'b0, 1'b0, 1'b1, P_EN | P_TDO, 4'hF);
    add(1'b0, 1'b1, 1'b1, P_EN, 4'hF);
    add(1'b1, 1'b1, 1'b1, P_EN | P_TDO, 4'hF);
    add(1'b1, 1'b0, 1'b0, P_Z, 4'hF);
    add(1'b0, 1'b0, 1'b0, P_Z, 4'hF);

    rst_n = 1'b0;
    tms   = 1'b1;
    tdi   = 1'b0;
    cto   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", P_Z, 4'hF);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      tms = vecs[i].tms;
      tdi = vecs[i].tdi;
      cto = vecs[i].cto;
      #1;
      chk($sformatf("vec%0d", i), vecs[i].exp_o, vecs[i].exp_ir);
      chk_cnt++;
      if (cti === vecs[i].tdi) pass_cnt++;
      else $display("FAIL cti_vec%0d: got %b, want %b", i, cti, vecs[i].tdi);
      @(posedge clk);
    end

    // Reset in the middle of a WRP_ALL DR shift
    cto = 1'b1;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    @(negedge clk);
    tms = 1'b0;
    #1;
    chk("pre_reset_shift", P_ALL | P_SHF | P_EN | P_TDO, 4'h3);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_shift", P_Z, 4'hF);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("after_reset_tlr", P_Z, 4'hF);
    @(posedge clk);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("no_restore_capture", P_Z, 4'hF);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("bypass_after_reset", P_EN, 4'hF);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/wrp_tap_ctrl.md
Name: wrp_tap_ctrl

Overview:
IEEE 1149.1-style TAP controller and instruction decoder that sequences the boundary scan wrapper chain: three input wrapper cells followed by three output wrapper cells.
- Runs on the test clock.
- Decodes TMS into the 16-state TAP FSM.
- Holds the instruction register and drives the chain controls: TDR_CAPTURE/SHIFT/UPDATE, the two chain-segment enables and the two cell-mode selects.
- Muxes TDO between the IR, the wrapper chain and a bypass bit.

Parameters:
IR_W, 4, instruction register width (min 2)
OP_WRP_IN, 4'h1, selects input-cell segment only
OP_WRP_OUT, 4'h2, selects output-cell segment only
OP_WRP_ALL, 4'h3, selects both segments
(all-ones = BYPASS; any undefined opcode behaves as BYPASS)

Ports:
TDR_TCK  in  1  test clock; all state changes on rising edge
TDR_TRESETN  in  1  asynchronous, active-low reset
TMS  in  1  test mode select
TDI  in  1  serial data in
TDO  out  1  serial data out
TDO_EN  out  1  high while TDO carries valid shift data
CTI  out  1  chain input to first wrapper cell (= TDI)
CTO  in  1  chain output from last wrapper cell
TDR_CAPTURE  out  1  capture strobe to wrapper cells
TDR_SHIFT  out  1  shift enable to wrapper cells
TDR_UPDATE  out  1  update strobe to wrapper cells
INSCANWRAP_TDR_EN  out  1  input-cell segment enable
OUTSCANWRAP_TDR_EN  out  1  output-cell segment enable
inscanwrap_sel  out  1  input cells drive wrapper (test) value to core
outscanwrap_sel  out  1  output cells drive wrapper (test) value to pad
ir_out  out  IR_W  active instruction (status/debug)

Behaviour:
- Reset (TDR_TRESETN low, async):
  - state = TEST_LOGIC_RESET; ir_active = all-ones (BYPASS); ir_shift = all-ones; bypass_reg = 0.
  - All strobes, enables and selects = 0; TDO = 0; TDO_EN = 0.
- TAP FSM: standard 16 states and transitions on TMS (TLR, RTI, SEL_DR, CAP_DR, SHF_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SHF_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR).
  - SEL_IR with TMS=1 goes to TLR.
  - Five consecutive TMS=1 clocks reach TLR from any state.
  - Entering TLR synchronously reloads ir_active = BYPASS.
- IR path:
  - CAP_IR: ir_shift <= {all-zeros, 2'b01}.
  - SHF_IR: ir_shift <= {TDI, ir_shift[IR_W-1:1]}.
  - UPD_IR: ir_active <= ir_shift.
  - ir_active is unchanged in every other state.
- Decode from ir_active, registered, so all decode outputs are glitch-free and stable between UPD_IR events:
  - wrp_in = (OP_WRP_IN or OP_WRP_ALL).
  - wrp_out = (OP_WRP_OUT or OP_WRP_ALL).
  - INSCANWRAP_TDR_EN = inscanwrap_sel = wrp_in.
  - OUTSCANWRAP_TDR_EN = outscanwrap_sel = wrp_out.
- Chain strobes are Moore decodes of the current state, gated by wrp_sel = wrp_in | wrp_out:
  - TDR_CAPTURE = (state==CAP_DR) & wrp_sel.
  - TDR_SHIFT = (state==SHF_DR) & wrp_sel.
  - TDR_UPDATE = (state==UPD_DR) & wrp_sel.
  - Each is high for exactly the cycles spent in that state.
  - All three stay 0 under BYPASS.
- Bypass register:
  - CAP_DR: bypass_reg <= 0.
  - SHF_DR: bypass_reg <= TDI.
  - Active only when wrp_sel = 0.
- CTI = TDI, combinational.
- TDO, combinational mux:
  - SHF_IR: ir_shift[0].
  - SHF_DR & wrp_sel: CTO.
  - SHF_DR & !wrp_sel: bypass_reg.
  - Otherwise 0.
  - TDO_EN = state in {SHF_IR, SHF_DR}.
- Latency: new instruction decode is visible the cycle after UPD_IR. A BYPASS DR path delays TDI by exactly 1 TCK.
- Reset mid-shift: all outputs clear immediately. Previous selects are not restored; ir_active = BYPASS.
- PAUSE states: strobes and shift are deasserted; chain contents hold.

Test Plan:
1. From reset, TMS=1 x5 then any path -> state TLR, ir_out=4'hF, all enables/selects 0.
2. Load OP_WRP_ALL via CAP_IR/SHF_IR (TDI LSB-first 1,1,0,0)/UPD_IR -> TDO in SHF_IR shows 1,0,0,0 (captured 01 pattern); next cycle INSCANWRAP_TDR_EN=OUTSCANWRAP_TDR_EN=1, both sels=1.
3. With WRP_ALL: CAP_DR, SHF_DR x6, EX1_DR, UPD_DR -> TDR_CAPTURE high 1 cycle, TDR_SHIFT high 6 cycles, TDR_UPDATE high 1 cycle; CTI tracks TDI; TDO equals CTO each shift cycle.
4. Load OP_WRP_IN -> only INSCANWRAP_TDR_EN/inscanwrap_sel =1; OUTSCANWRAP_TDR_EN/outscanwrap_sel =0.
5. BYPASS: DR shift of 1,0,1,1 -> TDO = 0,1,0,1; TDR_* strobes stay 0 throughout.
6. Assert TDR_TRESETN low during SHF_DR under WRP_ALL -> same cycle TDR_SHIFT=0, enables/sels=0, TDO_EN=0; after release, state TLR, ir_out=4'hF.
